// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
//   BCD_DIGITS  : default number of packed BCD input digits
//   BIN_W       : default binary result width (= number of shift steps)
//   CORR_THRESH : digit value at or above which a correction is applied
//   CORR_SUB    : amount subtracted from a digit needing correction
//   state_t     : sequencer state encoding
package bcd_to_binary_pkg;

    localparam int BCD_DIGITS = 10;
    localparam int BIN_W      = 32;

    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_SUB    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Handshake bundle between the decimal-entry producer, the converter and the
// consumer on the CPU side.
//   in_valid/in_ready/bcd              : request channel (producer -> converter)
//   out_valid/out_ready/bin/ovf/err_digit : result channel (converter -> consumer)
// Modports: slave = converter side, master = producer/consumer side.
interface bcd_to_binary_if #(
    parameter int DIGITS = bcd_to_binary_pkg::BCD_DIGITS,
    parameter int BIN_W  = bcd_to_binary_pkg::BIN_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin;
    logic                  ovf;
    logic                  err_digit;

    modport slave (
        input  in_valid, bcd, out_ready,
        output in_ready, out_valid, bin, ovf, err_digit
    );

    modport master (
        output in_valid, bcd, out_ready,
        input  in_ready, out_valid, bin, ovf, err_digit
    );
endinterface

// File: rtl/bcd_digit_correct.sv
// Per-digit correction for reverse double-dabble: a digit that is 8 or more
// after the right shift has 3 subtracted. Result is always >= 5, so it
// cannot underflow.
//   digit_in  : shifted BCD digit
//   digit_out : corrected digit
module bcd_digit_correct
    import bcd_to_binary_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    assign digit_out = (digit_in >= CORR_THRESH) ? (digit_in - CORR_SUB) : digit_in;
endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble converter: packed BCD in, unsigned binary
// out, one shift-and-correct step per clock.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : handshake bundle (slave side), see bcd_to_binary_if
//
//   state | meaning
//   IDLE  | ready for a new request
//   SHIFT | shifting {bcd_reg, bin_reg} right and correcting digits
//   DONE  | result held on bus until out_ready
module bcd_to_binary #(
    parameter int DIGITS = bcd_to_binary_pkg::BCD_DIGITS,
    parameter int BIN_W  = bcd_to_binary_pkg::BIN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_to_binary_if.slave     bus
);
    import bcd_to_binary_pkg::*;

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;

    logic               in_ready_q;
    logic               out_valid_q;
    logic [BIN_W-1:0]   bin_q;
    logic               ovf_q;
    logic               err_q;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_shift;
    logic [BCD_W-1:0]       bcd_corr;
    logic [BIN_W-1:0]       bin_shift;
    logic                   digit_bad;

    assign shifted   = {bcd_reg, bin_reg} >> 1;
    assign bcd_shift = shifted[BCD_W+BIN_W-1:BIN_W];
    assign bin_shift = shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_digit_correct u_corr (
            .digit_in  (bcd_shift[4*g +: 4]),
            .digit_out (bcd_corr[4*g +: 4])
        );
    end

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bcd_reg     <= '0;
            bin_reg     <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bin_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (digit_bad) begin
                            // Malformed input: report immediately, skip shifting.
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            bin_q       <= '0;
                            ovf_q       <= 1'b0;
                            err_q       <= 1'b1;
                        end else begin
                            state   <= SHIFT;
                            bcd_reg <= bus.bcd;
                            bin_reg <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_corr;
                    bin_reg <= bin_shift;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        // Anything left in the BCD register is value above 2^BIN_W.
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        bin_q       <= bin_shift;
                        ovf_q       <= |bcd_corr;
                        err_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bin       = bin_q;
    assign bus.ovf       = ovf_q;
    assign bus.err_digit = err_q;

endmodule
